// File: rtl/player_ctrl.sv
// Music player control FSM: song select with wrap, play/pause, restart strobe to the sequencer.
// Optional AUTO_NEXT_EN: at song end advance to the next song and keep playing.
module player_ctrl #(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next,
  input  logic              prev,
  input  logic              song_done,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song,
  output logic              busy
);

  localparam logic [SONG_W-1:0] LastSong = SONG_W'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    StReset   = 3'd0,
    StPaused  = 3'd1,
    StPlaying = 3'd2,
    StChange  = 3'd3,
    StEnd     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              play_q, play_d;
  logic              reset_play_q, reset_play_d;
  logic              busy_q, busy_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [SONG_W-1:0] song_inc, song_dec;
  logic              song_valid;

  // Wrap-around neighbours; NUM_SONGS need not be a power of two.
  always_comb begin
    song_inc = (song_q == LastSong) ? '0 : song_q + 1'b1;
    song_dec = (song_q == '0) ? LastSong : song_q - 1'b1;
  end

  assign song_valid = (32'(song_q) < NUM_SONGS);

  always_comb begin
    state_d      = state_q;
    play_d       = play_q;
    song_d       = song_q;
    reset_play_d = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      StReset: begin
        state_d = StPaused;
        play_d  = 1'b0;
        song_d  = '0;
      end

      StPaused, StPlaying: begin
        if (song_done && (state_q == StPlaying)) begin
          state_d      = StEnd;
          reset_play_d = 1'b1;
          busy_d       = 1'b1;
        end else if (next) begin
          state_d      = StChange;
          song_d       = song_inc;
          reset_play_d = 1'b1;
          busy_d       = 1'b1;
        end else if (prev) begin
          state_d      = StChange;
          song_d       = song_dec;
          reset_play_d = 1'b1;
          busy_d       = 1'b1;
        end else if (play_button) begin
          if (state_q == StPlaying) begin
            state_d = StPaused;
            play_d  = 1'b0;
          end else begin
            state_d = StPlaying;
            play_d  = 1'b1;
          end
        end
      end

      StChange: begin
        state_d = play_q ? StPlaying : StPaused;
      end

      StEnd: begin
`ifdef AUTO_NEXT_EN
        // Second restart strobe so the sequencer starts the new song from its first note.
        state_d      = StPlaying;
        song_d       = song_inc;
        play_d       = 1'b1;
        reset_play_d = 1'b1;
`else
        state_d = StPaused;
        play_d  = 1'b0;
`endif
      end

      default: begin
        state_d = StPaused;
        play_d  = 1'b0;
        song_d  = song_valid ? song_q : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReset;
      play_q       <= 1'b0;
      song_q       <= '0;
      reset_play_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      play_q       <= play_d;
      song_q       <= song_d;
      reset_play_q <= reset_play_d;
      busy_q       <= busy_d;
    end
  end

  assign play       = play_q;
  assign reset_play = reset_play_q;
  assign song       = song_q;
  assign busy       = busy_q;

  song_in_range_a : assert property (@(posedge clk) disable iff (reset) song_valid);

`ifndef AUTO_NEXT_EN
  rp_single_cycle_a : assert property (@(posedge clk) disable iff (reset)
    reset_play |=> !reset_play);
`endif

endmodule

// File: tb/tb_player_ctrl.sv
// Randomized self-checking bench for player_ctrl (NUM_SONGS=3) against a behavioural model.
module tb_player_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_button = 1'b0;
  logic          next = 1'b0;
  logic          prev = 1'b0;
  logic          song_done = 1'b0;
  logic          play;
  logic          reset_play;
  logic [SW-1:0] song;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: what the player should be doing, in plain terms.
  int m_song    = 0;
  bit m_play    = 0;
  bit m_rp      = 1;
  bit m_busy    = 1;
  bit m_ending  = 0;

  player_ctrl #(
    .NUM_SONGS(N),
    .SONG_W   (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_button(play_button),
    .next       (next),
    .prev       (prev),
    .song_done  (song_done),
    .play       (play),
    .reset_play (reset_play),
    .song       (song),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, compare all outputs.
  task automatic step(input bit r, input bit pb, input bit nx, input bit pv, input bit sd);
    reset       = r;
    play_button = pb;
    next        = nx;
    prev        = pv;
    song_done   = sd;
    @(posedge clk);
    if (r) begin
      m_play = 0; m_song = 0; m_rp = 1; m_busy = 1; m_ending = 0;
    end else if (m_busy) begin
      // Recovery cycle after reset, a song change or a song end; inputs dropped.
      m_busy = 0;
      m_rp   = 0;
      if (m_ending) begin
`ifdef AUTO_NEXT_EN
        m_song = (m_song + 1) % N;
        m_play = 1;
        m_rp   = 1;
`else
        m_play = 0;
`endif
      end
      m_ending = 0;
    end else if (sd && m_play) begin
      m_busy = 1; m_rp = 1; m_ending = 1;
    end else if (nx) begin
      m_song = (m_song + 1) % N; m_busy = 1; m_rp = 1;
    end else if (pv) begin
      m_song = (m_song + N - 1) % N; m_busy = 1; m_rp = 1;
    end else if (pb) begin
      m_play = !m_play; m_rp = 0;
    end else begin
      m_rp = 0;
    end
    #1;
    check_eq("play", 32'(play), 32'(m_play));
    check_eq("reset_play", 32'(reset_play), 32'(m_rp));
    check_eq("song", 32'(song), 32'(m_song));
    check_eq("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    idle(2);
    // Play/pause toggling while paused on song 0.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // Forward wrap 2->0 and backward wrap 0->2 with three songs.
    step(0, 0, 1, 0, 0); idle(1);
    step(0, 0, 1, 0, 0); idle(1);
    step(0, 0, 1, 0, 0); idle(1);
    step(0, 0, 0, 1, 0); idle(1);
    // Go to song 1 and play, then song_done+next+play_button together.
    step(0, 0, 1, 0, 0); idle(1);
    step(0, 0, 1, 0, 0); idle(1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1); idle(3);
    // next+prev together from song 1, then next while busy is dropped.
    step(0, 0, 0, 1, 0); idle(1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0); idle(1);
    // Reset while playing.
    step(0, 1, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0); idle(2);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
